neuron_mac_accumulator: RTL and testbench

//  Sequential pre-activation stage of one neuron: serially multiplies N_INPUTS signed

---
 rtl/neuron_mac_accumulator_if.sv | 27 ++
 rtl/neuron_mac_accumulator.sv | 101 ++++++++++
 tb/tb_neuron_mac_accumulator.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_mac_accumulator_if.sv
// Handshake bundle between a neuron MAC stage and its producer/consumer.
// The master drives start, bias, input beats and z_ready; the slave is the MAC block.
interface neuron_mac_accumulator_if #(
   parameter int unsigned DATA_W = 8
);
   logic                     start;
   logic signed [DATA_W-1:0] bias;
   logic                     x_valid;
   logic                     x_ready;
   logic signed [DATA_W-1:0] x_data;
   logic signed [DATA_W-1:0] w_data;
   logic                     z_valid;
   logic                     z_ready;
   logic signed [DATA_W-1:0] z_value;
   logic                     overflow;
   logic                     busy;

   modport master (
      output start, bias, x_valid, x_data, w_data, z_ready,
      input  x_ready, z_valid, z_value, overflow, busy
   );

   modport slave (
      input  start, bias, x_valid, x_data, w_data, z_ready,
      output x_ready, z_valid, z_value, overflow, busy
   );
endinterface

// File: rtl/neuron_mac_accumulator.sv
// Serial multiply-accumulate pre-activation stage of one neuron: bias plus N x*w products,
// floored back to Q3.4 and saturated to a signed DATA_W z_value for the activation LUT.
module neuron_mac_accumulator #(
   parameter int unsigned N_INPUTS  = 2,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned FRAC_BITS = 4,
   parameter int unsigned ACC_W     = 20
) (
   input logic                       clk,
   input logic                       rst,
   neuron_mac_accumulator_if.slave   bus
);

   localparam int unsigned CntW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(N_INPUTS - 1);
   localparam logic signed [ACC_W-1:0] ZMax = ACC_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] ZMin = ~ZMax;

   typedef enum logic [1:0] {StIdle, StAccum, StSat, StOut} state_e;

   state_e                   state_q, state_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [CntW-1:0]          count_q, count_d;
   logic signed [DATA_W-1:0] z_q, z_d;
   logic                     ovf_q, ovf_d;

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    bias_ext;
   logic signed [ACC_W-1:0]    t;

   assign prod     = bus.x_data * bus.w_data;
   assign prod_ext = ACC_W'(prod);
   assign bias_ext = ACC_W'(bus.bias);
   // Arithmetic shift floors toward -inf, so small negative sums become -1, not 0.
   assign t        = acc_q >>> FRAC_BITS;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         acc_q   <= '0;
         count_q <= '0;
         z_q     <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         z_q     <= z_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      z_d     = z_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               acc_d   = bias_ext <<< FRAC_BITS;
               count_d = '0;
               state_d = StAccum;
            end
         end
         StAccum: begin
            if (bus.x_valid) begin
               acc_d   = acc_q + prod_ext;
               count_d = count_q + 1'b1;
               if (count_q == LastCnt) state_d = StSat;
            end
         end
         StSat: begin
            if (t > ZMax) begin
               z_d   = ZMax[DATA_W-1:0];
               ovf_d = 1'b1;
            end else if (t < ZMin) begin
               z_d   = ZMin[DATA_W-1:0];
               ovf_d = 1'b1;
            end else begin
               z_d   = t[DATA_W-1:0];
               ovf_d = 1'b0;
            end
            state_d = StOut;
         end
         StOut: begin
            if (bus.z_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.x_ready  = (state_q == StAccum);
   assign bus.z_valid  = (state_q == StOut);
   assign bus.busy     = (state_q != StIdle);
   assign bus.z_value  = z_q;
   assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Scoreboard bench for neuron_mac_accumulator: the driver pushes model results, a monitor
// pops them on each output handshake and also watches hold stability and spurious outputs.
module tb_neuron_mac_accumulator;

   localparam int DW = 8;

   typedef struct {
      int z;
      int ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   neuron_mac_accumulator_if #(.DATA_W(DW)) bus ();

   neuron_mac_accumulator #(
      .N_INPUTS  (2),
      .DATA_W    (DW),
      .FRAC_BITS (4),
      .ACC_W     (20)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   vectors = 0;
   int   miscompares = 0;
   exp_t exp_q[$];

   task automatic check(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Reference: exact real-valued sum in units of 2^-8, floored to units of 2^-4, clipped.
   function automatic exp_t model(input int b, input int x0, input int w0,
                                  input int x1, input int w1);
      exp_t e;
      int   acc;
      int   t;
      acc = b * 16 + x0 * w0 + x1 * w1;
      t   = (acc >= 0) ? acc / 16 : -((-acc + 15) / 16);
      if (t > 127) begin
         e.z = 127; e.ovf = 1;
      end else if (t < -128) begin
         e.z = -128; e.ovf = 1;
      end else begin
         e.z = t; e.ovf = 0;
      end
      return e;
   endfunction

   // Monitor: compare on handshake, enforce stability while z_ready is withheld.
   logic prev_hold = 1'b0;
   int   prev_z = 0;
   int   prev_o = 0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.z_valid) begin
            if (exp_q.size() == 0) check("spurious_z_valid", int'(bus.z_valid), 0);
            if (prev_hold) begin
               check("z_value_stable", int'(bus.z_value), prev_z);
               check("overflow_stable", int'(bus.overflow), prev_o);
            end
            if (bus.z_ready) begin
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("z_value", int'(bus.z_value), e.z);
                  check("overflow", int'(bus.overflow), e.ovf);
               end
               prev_hold = 1'b0;
            end else begin
               prev_hold = 1'b1;
               prev_z    = int'(bus.z_value);
               prev_o    = int'(bus.overflow);
            end
         end else begin
            prev_hold = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic eval(input int b, input int x0, input int w0, input int x1, input int w1,
                       input int gap, input int hold, input bit noise);
      int   xs[2];
      int   ws[2];
      int   n;
      exp_t e;
      xs = '{x0, x1};
      ws = '{w0, w1};
      e  = model(b, x0, w0, x1, w1);
      exp_q.push_back(e);
      if (noise) begin
         bus.x_valid = 1'b1;
         repeat (3) begin
            bus.x_data = 8'($urandom);
            bus.w_data = 8'($urandom);
            tick();
            check("x_ready_idle", int'(bus.x_ready), 0);
         end
         bus.x_valid = 1'b0;
      end
      bus.z_ready = (hold == 0);
      bus.start   = 1'b1;
      bus.bias    = 8'(b);
      tick();
      bus.start = noise;
      bus.bias  = 8'($urandom);
      check("busy_after_start", int'(bus.busy), 1);
      for (int i = 0; i < 2; i++) begin
         repeat (gap) begin
            bus.x_data = 8'($urandom);
            bus.w_data = 8'($urandom);
            tick();
         end
         check("x_ready_accum", int'(bus.x_ready), 1);
         bus.x_valid = 1'b1;
         bus.x_data  = 8'(xs[i]);
         bus.w_data  = 8'(ws[i]);
         tick();
         bus.x_valid = 1'b0;
         bus.x_data  = 8'($urandom);
         bus.w_data  = 8'($urandom);
      end
      check("z_valid_during_sat", int'(bus.z_valid), 0);
      tick();
      check("z_valid_latency", int'(bus.z_valid), 1);
      repeat (hold) tick();
      bus.start   = 1'b0;
      bus.z_ready = 1'b1;
      n = 0;
      while (bus.z_valid && n < 20) begin
         tick();
         n++;
      end
      check("z_valid_dropped", int'(bus.z_valid), 0);
      check("busy_idle", int'(bus.busy), 0);
      check("z_value_kept_idle", int'(bus.z_value), e.z);
      bus.z_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      int rb, rx0, rw0, rx1, rw1, rh;
      bus.start   = 1'b0;
      bus.bias    = '0;
      bus.x_valid = 1'b0;
      bus.x_data  = '0;
      bus.w_data  = '0;
      bus.z_ready = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      check("rst_x_ready", int'(bus.x_ready), 0);
      check("rst_z_valid", int'(bus.z_valid), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_z_value", int'(bus.z_value), 0);
      check("rst_overflow", int'(bus.overflow), 0);
      rst = 1'b0;
      tick();

      eval(-16, 16, 32, 16, 32, 0, 0, 1'b0);
      eval(0, 127, 127, 127, 127, 0, 0, 1'b0);
      eval(0, 127, -128, 127, -128, 0, 1, 1'b0);
      eval(0, 1, -1, 0, 0, 0, 0, 1'b0);
      eval(-16, 16, 32, 16, 32, 3, 5, 1'b0);

      // Abort after one accepted beat; the partial sum must vanish.
      bus.start = 1'b1;
      bus.bias  = 8'(100);
      tick();
      bus.start   = 1'b0;
      bus.x_valid = 1'b1;
      bus.x_data  = 8'(127);
      bus.w_data  = 8'(127);
      tick();
      bus.x_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("abort_busy", int'(bus.busy), 0);
      check("abort_x_ready", int'(bus.x_ready), 0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      eval(-16, 16, 32, 16, 32, 0, 0, 1'b0);

      eval(-16, 16, 32, 16, 32, 1, 3, 1'b1);

      for (int k = 0; k < 24; k++) begin
         rb  = int'($urandom_range(255)) - 128;
         rx0 = int'($urandom_range(255)) - 128;
         rw0 = int'($urandom_range(255)) - 128;
         rx1 = int'($urandom_range(255)) - 128;
         rw1 = int'($urandom_range(255)) - 128;
         if (k % 3 == 0) begin
            rw0 = rw0 / 16;
            rw1 = rw1 / 16;
         end
         rh = int'($urandom_range(3));
         eval(rb, rx0, rw0, rx1, rw1, int'($urandom_range(2)), rh,
              (rh > 0) ? 1'($urandom) : 1'b0);
      end

      repeat (3) tick();
      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
